// File: rtl/mrd_rdx_p2s.sv
// Radix butterfly vector FIFO with a parallel-to-serial output stage.
// Each 5-wide vector becomes radix serial samples on a valid/ready stream.
module mrd_rdx_p2s #(
  parameter int wData = 18,
  parameter int DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_val,
  input  logic signed [wData-1:0] din_real [0:4],
  input  logic signed [wData-1:0] din_imag [0:4],
  input  logic [2:0]              radix,
  input  logic                    out_rdy,
  input  logic                    ovf_clr,
  output logic                    out_val,
  output logic signed [wData-1:0] dout_real,
  output logic signed [wData-1:0] dout_imag,
  output logic                    sop,
  output logic                    eop,
  output logic                    ovf,
  output logic [$clog2(DEPTH):0]  level
);

  localparam int AW = $clog2(DEPTH);

  logic signed [wData-1:0] re_q [DEPTH][0:4];
  logic signed [wData-1:0] im_q [DEPTH][0:4];
  logic [2:0]              rdx_q [DEPTH];

  logic [AW-1:0] wr_q, wr_d;
  logic [AW-1:0] rd_q, rd_d;
  logic [AW:0]   lvl_q, lvl_d;
  logic [2:0]    k_q, k_d;
  logic          ovf_q, ovf_d;

  logic       full, xfer, pop, push, drop;
  logic [2:0] rdx_eff, rdx_hd, k_last;

  always_comb begin
    rdx_eff = ((radix >= 3'd2) && (radix <= 3'd5)) ? radix : 3'd5;
    rdx_hd  = rdx_q[rd_q];
    k_last  = rdx_hd - 3'd1;
    full    = (lvl_q == (AW+1)'(DEPTH));
    out_val = (lvl_q != '0);
    xfer    = out_val && out_rdy;
    pop     = xfer && (k_q == k_last);
    // a full FIFO still takes the vector when the head leaves this edge
    push    = in_val && (!full || pop);
    drop    = in_val && full && !pop;
    sop     = out_val && (k_q == 3'd0);
    eop     = out_val && (k_q == k_last);
    dout_real = out_val ? re_q[rd_q][k_q] : '0;
    dout_imag = out_val ? im_q[rd_q][k_q] : '0;
    ovf     = ovf_q;
    level   = lvl_q;

    wr_d  = push ? wr_q + 1'b1 : wr_q;
    rd_d  = pop  ? rd_q + 1'b1 : rd_q;
    lvl_d = lvl_q;
    if (push && !pop)
      lvl_d = lvl_q + 1'b1;
    else if (pop && !push)
      lvl_d = lvl_q - 1'b1;
    k_d = k_q;
    if (pop)
      k_d = 3'd0;
    else if (xfer)
      k_d = k_q + 3'd1;
    ovf_d = drop ? 1'b1 : (ovf_clr ? 1'b0 : ovf_q);
  end

  always_ff @(posedge clk) begin
    if (push) begin
      for (int i = 0; i < 5; i++) begin
        re_q[wr_q][i] <= din_real[i];
        im_q[wr_q][i] <= din_imag[i];
      end
      rdx_q[wr_q] <= rdx_eff;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      lvl_q <= '0;
      k_q   <= '0;
      ovf_q <= 1'b0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      lvl_q <= lvl_d;
      k_q   <= k_d;
      ovf_q <= ovf_d;
    end
  end

endmodule

// File: doc/mrd_rdx_p2s.md
MRD_RDX_P2S -- requirements
Module: mrd_rdx_p2s

Interface
REQ-001 Parameter: wData, default 18, sample width of each real and imaginary part.
REQ-002 Parameter: DEPTH, default 4, vector FIFO depth in entries; power of two, at least 2.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset; asynchronous assert, active-low.
REQ-005 in_val  input  1  one-cycle strobe marking a valid 5-element vector from the radix butterfly.
REQ-006 din_real[0:4], din_imag[0:4]  input  5 x wData signed  butterfly output vector.
REQ-007 radix  input  3  count of valid elements in the vector; sampled with in_val.
REQ-008 out_rdy  input  1  downstream ready.
REQ-009 ovf_clr  input  1  synchronous clear for ovf.
REQ-010 out_val  output  1  serial sample valid.
REQ-011 dout_real, dout_imag  output  wData signed  serial sample.
REQ-012 sop, eop  output  1  first and last element of the current vector; meaningful only while out_val=1.
REQ-013 ovf  output  1  sticky overflow flag.
REQ-014 level  output  $clog2(DEPTH)+1  number of occupied FIFO entries.

Function
REQ-015 The block SHALL convert each accepted 5-wide vector into radix serial samples, in element order 0..radix-1, on a valid/ready stream.
REQ-016 Each FIFO entry SHALL store 10 samples plus the effective radix: radix values 2..5 are used as-is; 0, 1, 6 and 7 are stored as 5.
REQ-017 Push: when in_val=1 and the FIFO is not full, the vector SHALL be written at that edge.
REQ-018 A push into a full FIFO SHALL be accepted only if a pop occurs on the same edge.
REQ-019 Otherwise, a push into a full FIFO SHALL drop the vector, leave the FIFO contents unchanged, and set ovf=1 at that edge.
REQ-020 ovf SHALL stay at 1 until ovf_clr=1.
REQ-021 If ovf_clr=1 and a new overflow occur on the same edge, ovf SHALL be 1.
REQ-022 out_val SHALL be 1 whenever level>0.
REQ-023 dout_real/dout_imag SHALL be driven combinationally from the head entry at element index k; storage is registered.
REQ-024 Latency: a vector pushed into an empty FIFO at edge t SHALL present element 0 with out_val=1 in the cycle following edge t.
REQ-025 A transfer occurs on an edge where out_val=1 and out_rdy=1.
REQ-026 On a transfer with k < radix_head-1, k SHALL increment.
REQ-027 On a transfer with k = radix_head-1, k SHALL return to 0 and the head SHALL pop.
REQ-028 sop SHALL equal (k==0).
REQ-029 eop SHALL equal (k==radix_head-1).
REQ-030 While out_rdy=0, outputs SHALL hold stable and k SHALL not change.
REQ-031 Read and write pointers SHALL wrap modulo DEPTH.
REQ-032 level SHALL update as +1 on push only, -1 on pop only, and unchanged on simultaneous push and pop.
REQ-033 When level=0, out_val, sop and eop SHALL be 0, and dout SHALL be 0.

Reset
REQ-034 While rst_n=0, the block SHALL asynchronously force the following, and hold them: out_val=0, sop=0, eop=0, dout_real=0, dout_imag=0, ovf=0, level=0, both pointers 0, k=0.
REQ-035 in_val asserted during reset SHALL be ignored.
REQ-036 Reset asserted mid-vector SHALL discard all stored vectors; after release, the first output SHALL be element 0 of the next vector pushed.

Verification
REQ-037 Single vector: push radix=3, din_real={10,20,30,40,50}, out_rdy=1 -> serial outputs 10, 20, 30 on three consecutive cycles starting one cycle after the push; sop on 10, eop on 30; then out_val=0.
REQ-038 Backpressure: radix=5 vector with out_rdy toggling 1,0,1,0... -> all 5 elements delivered in order, each held unchanged while out_rdy=0, with no duplicates.
REQ-039 Overflow: DEPTH=4, out_rdy=0, push 5 vectors -> level=4, ovf=1, vector 5 lost; with out_rdy=1, vectors 1-4 drain intact.
REQ-040 Simultaneous push/pop at full: level=4, push on the same edge as the eop transfer -> level stays 4 and ovf stays 0.
REQ-041 Illegal radix: radix=7, din_imag={-1,-2,-3,-4,-5} -> 5 samples output, -1 to -5.
REQ-042 Mid-operation reset: rst_n=0 after 2 elements of a radix=4 vector -> outputs 0 immediately; after release, a new vector starts at element 0 with level=1.
